// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: ALU control codes,
// RV32I opcode/funct fields, skid FSM states and the issue payload.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CODE_W-1:0] ALU_AND  = 4'b0001;
    localparam logic [CODE_W-1:0] ALU_OR   = 4'b0010;
    localparam logic [CODE_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [CODE_W-1:0] ALU_SLL  = 4'b0100;
    localparam logic [CODE_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [CODE_W-1:0] ALU_SRA  = 4'b0110;
    localparam logic [CODE_W-1:0] ALU_SUB  = 4'b0111;
    localparam logic [CODE_W-1:0] ALU_SLTU = 4'b1000;
    localparam logic [CODE_W-1:0] ALU_SLT  = 4'b1001;
    localparam logic [CODE_W-1:0] ALU_NOP  = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [CODE_W-1:0] ctrl;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic              illegal;
    } issue_t;

    // Shared OP / OP-IMM mapping; alt selects SUB/SRA and must already be
    // qualified by the caller (OP-IMM has no SUBI).
    function automatic logic [CODE_W-1:0] alu_op_code(input logic [2:0] funct3,
                                                      input logic       alt);
        logic [CODE_W-1:0] code;
        case (funct3)
            F3_ADD_SUB: code = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     code = ALU_SLL;
            F3_SLT:     code = ALU_SLT;
            F3_SLTU:    code = ALU_SLTU;
            F3_XOR:     code = ALU_XOR;
            F3_SRL_SRA: code = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      code = ALU_OR;
            default:    code = ALU_AND;
        endcase
        return code;
    endfunction

    // The ALU shifts by the whole operand, so shift amounts are cut to 5 bits.
    function automatic logic [DATA_W-1:0] shamt_ext(input logic [4:0] amount);
        return {{(DATA_W-5){1'b0}}, amount};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into the ALU issue payload {ctrl, in1, in2, illegal}.
// Define ALU_ISSUE_ILLEGAL_DETECT_EN to flag undecodable encodings as NOP commands.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output issue_t            payload
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_shift;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_u;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    assign imm_i    = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign imm_s    = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u    = {instr[31:12], 12'b0};

`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
    logic [6:0] funct7;
    logic       legal;

    assign funct7 = instr[31:25];
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path through the case infers a latch.
        payload = '{ctrl: ALU_ADD, in1: '0, in2: '0, illegal: 1'b0};
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
        legal = 1'b1;
`endif
        case (opcode)
            OPC_OP: begin
                payload.in1  = rs1_data;
                payload.in2  = is_shift ? shamt_ext(rs2_data[4:0]) : rs2_data;
                payload.ctrl = alu_op_code(funct3, instr[30]);
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
`endif
            end
            OPC_OP_IMM: begin
                payload.in1  = rs1_data;
                payload.in2  = is_shift ? shamt_ext(instr[24:20]) : imm_i;
                payload.ctrl = alu_op_code(funct3, (funct3 == F3_SRL_SRA) && instr[30]);
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
                if (funct3 == F3_SLL) begin
                    legal = (funct7 == F7_BASE);
                end else if (funct3 == F3_SRL_SRA) begin
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end
`endif
            end
            OPC_LUI: begin
                payload.in2 = imm_u;
            end
            OPC_AUIPC: begin
                payload.in1 = pc;
                payload.in2 = imm_u;
            end
            OPC_LOAD: begin
                payload.in1 = rs1_data;
                payload.in2 = imm_i;
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
                legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`endif
            end
            OPC_STORE: begin
                payload.in1 = rs1_data;
                payload.in2 = imm_s;
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
                legal = funct3 inside {3'b000, 3'b001, 3'b010};
`endif
            end
            OPC_BRANCH: begin
                payload.in1 = rs1_data;
                payload.in2 = rs2_data;
                case (funct3)
                    F3_BEQ, F3_BNE:   payload.ctrl = ALU_SUB;
                    F3_BLT, F3_BGE:   payload.ctrl = ALU_SLT;
                    F3_BLTU, F3_BGEU: payload.ctrl = ALU_SLTU;
                    default: begin
                        payload.ctrl = ALU_SUB;
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
                        legal = 1'b0;
`endif
                    end
                endcase
            end
            default: begin
                // Unknown opcodes fall back to rs1 + I-immediate when not flagged.
                payload.in1 = rs1_data;
                payload.in2 = imm_i;
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
                legal = 1'b0;
`endif
            end
        endcase
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
        if (!legal) begin
            payload = '{ctrl: ALU_NOP, in1: '0, in2: '0, illegal: 1'b1};
        end
`endif
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decodes RV32I into ALU commands behind a 2-entry
// skid buffer. Optional macro ALU_ISSUE_ILLEGAL_DETECT_EN enables illegal flagging.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = DATA_W,
    parameter int CTRL_W = CODE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic              alu_valid_o,
    input  logic              alu_ready_i,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [XLEN-1:0]   alu_in1_o,
    output logic [XLEN-1:0]   alu_in2_o,
    output logic              illegal_o
);

    skid_state_e state_q, state_d;
    issue_t      dec_payload;
    issue_t      out_q;
    issue_t      skid_q;
    logic        ready_q;
    logic        accept;
    logic        out_fire;
    logic        load_out;
    logic        load_skid;
    logic        move_skid;

    alu_issue_decode u_decode (
        .instr    (instr_i),
        .pc       (pc_i),
        .rs1_data (rs1_data_i),
        .rs2_data (rs2_data_i),
        .payload  (dec_payload)
    );

    assign accept   = instr_valid_i && ready_q;
    assign out_fire = (state_q != ST_EMPTY) && alu_ready_i;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_ONE;
                    load_out = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && out_fire) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d   = ST_ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Ready is registered from the next state, so alu_ready_i never reaches it combinationally.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
            if (load_out) begin
                out_q <= dec_payload;
            end else if (move_skid) begin
                out_q <= skid_q;
            end
        end
    end

    // NOTE: the skid entry has no reset; it is only read in ST_TWO, which reset leaves.
    always_ff @(posedge clk_i) begin
        if (load_skid) begin
            skid_q <= dec_payload;
        end
    end

    assign instr_ready_o = ready_q;
    assign alu_valid_o   = (state_q != ST_EMPTY);
    assign alu_ctrl_o    = out_q.ctrl;
    assign alu_in1_o     = out_q.in1;
    assign alu_in2_o     = out_q.in2;
    assign illegal_o     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized
// traffic against a queue-based reference model of the issue stage.
`timescale 1ns/1ps
module tb_alu_issue_stage;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_AND  = 4'b0001;
    localparam logic [3:0] C_OR   = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SRA  = 4'b0110;
    localparam logic [3:0] C_SUB  = 4'b0111;
    localparam logic [3:0] C_SLTU = 4'b1000;
    localparam logic [3:0] C_SLT  = 4'b1001;
    localparam logic [3:0] C_NOP  = 4'b1111;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        logic        ill;
    } cmd_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        alu_valid_o;
    logic        alu_ready_i = 1'b0;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_in1_o;
    logic [31:0] alu_in2_o;
    logic        illegal_o;

    int   checks = 0;
    int   failures = 0;
    cmd_t exp_q[$];
    logic exp_ready = 1'b0;

    always #5 clk_i = ~clk_i;

    alu_issue_stage dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .alu_valid_o   (alu_valid_o),
        .alu_ready_i   (alu_ready_i),
        .alu_ctrl_o    (alu_ctrl_o),
        .alu_in1_o     (alu_in1_o),
        .alu_in2_o     (alu_in2_o),
        .illegal_o     (illegal_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode: classify the instruction, then pick operands from the ISA rules.
    function automatic cmd_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        cmd_t        c;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [11:0] i12;
        logic [11:0] s12;
        logic [31:0] ii;
        logic [31:0] si;
        logic [31:0] ui;
        opc = ins[6:0];
        f3  = ins[14:12];
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        ii  = 32'($signed(i12));
        si  = 32'($signed(s12));
        ui  = ins & 32'hFFFF_F000;
        c   = '{ctrl: C_ADD, in1: 32'd0, in2: 32'd0, ill: 1'b0};
        case (opc)
            7'h33, 7'h13: begin
                c.in1 = a;
                c.in2 = (opc == 7'h33) ? b : ii;
                case (f3)
                    3'd0: c.ctrl = (opc == 7'h33 && ins[30]) ? C_SUB : C_ADD;
                    3'd1: begin c.ctrl = C_SLL; c.in2 = c.in2 % 32'd32; end
                    3'd2: c.ctrl = C_SLT;
                    3'd3: c.ctrl = C_SLTU;
                    3'd4: c.ctrl = C_XOR;
                    3'd5: begin c.ctrl = ins[30] ? C_SRA : C_SRL; c.in2 = c.in2 % 32'd32; end
                    3'd6: c.ctrl = C_OR;
                    default: c.ctrl = C_AND;
                endcase
            end
            7'h37: c.in2 = ui;
            7'h17: begin c.in1 = pc; c.in2 = ui; end
            7'h03: begin c.in1 = a; c.in2 = ii; end
            7'h23: begin c.in1 = a; c.in2 = si; end
            7'h63: begin
                c.in1 = a;
                c.in2 = b;
                if (f3 == 3'd0 || f3 == 3'd1)      c.ctrl = C_SUB;
                else if (f3 == 3'd4 || f3 == 3'd5) c.ctrl = C_SLT;
                else                               c.ctrl = C_SLTU;
            end
            default: begin
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
                c = '{ctrl: C_NOP, in1: 32'd0, in2: 32'd0, ill: 1'b1};
`else
                c.in1 = a;
                c.in2 = ii;
`endif
            end
        endcase
        return c;
    endfunction

    // Random legal RV32I ALU-relevant encodings, plus unknown opcodes.
    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [2:0]  f3;
        ins = $urandom;
        f3  = ins[14:12];
        case ($urandom_range(0, 7))
            0: begin
                ins[6:0]   = 7'h33;
                ins[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            1: begin
                ins[6:0] = 7'h13;
                if (f3 == 3'd1) ins[31:25] = 7'h00;
                if (f3 == 3'd5) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            2: ins[6:0] = 7'h37;
            3: ins[6:0] = 7'h17;
            4: begin
                ins[6:0] = 7'h03;
                case ($urandom_range(0, 4))
                    0: ins[14:12] = 3'd0;
                    1: ins[14:12] = 3'd1;
                    2: ins[14:12] = 3'd2;
                    3: ins[14:12] = 3'd4;
                    default: ins[14:12] = 3'd5;
                endcase
            end
            5: begin
                ins[6:0]   = 7'h23;
                ins[14:12] = 3'($urandom_range(0, 2));
            end
            6: begin
                ins[6:0] = 7'h63;
                if (f3 == 3'd2 || f3 == 3'd3) ins[14:12] = 3'd6;
            end
            default: ins[6:0] = ($urandom_range(0, 1) == 1) ? 7'h7F : 7'h0B;
        endcase
        return ins;
    endfunction

    task automatic check_outputs();
        check("valid", 64'(alu_valid_o), 64'(exp_q.size() != 0));
        check("ready", 64'(instr_ready_o), 64'(exp_ready));
        if (exp_q.size() != 0) begin
            check("ctrl", 64'(alu_ctrl_o), 64'(exp_q[0].ctrl));
            check("in1", 64'(alu_in1_o), 64'(exp_q[0].in1));
            check("in2", 64'(alu_in2_o), 64'(exp_q[0].in2));
            check("illegal", 64'(illegal_o), 64'(exp_q[0].ill));
        end
    endtask

    // One clock: check current outputs, drive inputs, update model across the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic rdy);
        logic acc;
        logic fire;
        check_outputs();
        instr_valid_i = v;
        instr_i       = ins;
        pc_i          = pc;
        rs1_data_i    = a;
        rs2_data_i    = b;
        alu_ready_i   = rdy;
        acc  = v && exp_ready;
        fire = (exp_q.size() != 0) && rdy;
        @(posedge clk_i);
        if (fire) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(ref_decode(ins, pc, a, b));
        exp_ready = (exp_q.size() < 2);
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        rst_i         = 1'b1;
        instr_valid_i = 1'b0;
        @(posedge clk_i);
        exp_q.delete();
        exp_ready = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_valid", 64'(alu_valid_o), 64'd0);
        check("rst_ready", 64'(instr_ready_o), 64'd0);
        check("rst_ctrl", 64'(alu_ctrl_o), 64'd0);
        check("rst_in1", 64'(alu_in1_o), 64'd0);
        check("rst_in2", 64'(alu_in2_o), 64'd0);
        check("rst_illegal", 64'(illegal_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk_i);
        apply_reset();
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        check("ready_after_rst", 64'(instr_ready_o), 64'd1);

        // ADD, 1-cycle latency
        step(1'b1, 32'h00B50533, 32'd0, 32'd5, 32'd7, 1'b1);
        check("add_valid", 64'(alu_valid_o), 64'd1);
        check("add_ctrl", 64'(alu_ctrl_o), 64'(C_ADD));
        check("add_in1", 64'(alu_in1_o), 64'd5);
        check("add_in2", 64'(alu_in2_o), 64'd7);
        // SUB
        step(1'b1, 32'h40B50533, 32'd0, 32'd9, 32'd4, 1'b1);
        check("sub_ctrl", 64'(alu_ctrl_o), 64'(C_SUB));
        // SRAI 3
        step(1'b1, 32'h40355513, 32'd0, 32'h8000_0000, 32'd0, 1'b1);
        check("srai_ctrl", 64'(alu_ctrl_o), 64'(C_SRA));
        check("srai_in2", 64'(alu_in2_o), 64'd3);
        // SLL with rs2 amount above 31
        step(1'b1, 32'h00B51533, 32'd0, 32'd1, 32'h25, 1'b1);
        check("sll_ctrl", 64'(alu_ctrl_o), 64'(C_SLL));
        check("sll_in2", 64'(alu_in2_o), 64'h5);
        // LUI and AUIPC
        step(1'b1, 32'h12345537, 32'd0, 32'hDEAD_BEEF, 32'd0, 1'b1);
        check("lui_ctrl", 64'(alu_ctrl_o), 64'(C_ADD));
        check("lui_in1", 64'(alu_in1_o), 64'd0);
        check("lui_in2", 64'(alu_in2_o), 64'h1234_5000);
        step(1'b1, 32'h12345517, 32'h100, 32'd0, 32'd0, 1'b1);
        check("auipc_in1", 64'(alu_in1_o), 64'h100);
        check("auipc_in2", 64'(alu_in2_o), 64'h1234_5000);
        // All-ones encoding
        step(1'b1, 32'hFFFF_FFFF, 32'd0, 32'h11, 32'h22, 1'b1);
`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
        check("ill_ctrl", 64'(alu_ctrl_o), 64'(C_NOP));
        check("ill_flag", 64'(illegal_o), 64'd1);
`else
        check("ill_ctrl", 64'(alu_ctrl_o), 64'(C_ADD));
        check("ill_flag", 64'(illegal_o), 64'd0);
`endif
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);

        // Backpressure: A, B accepted, C held, then in-order drain without gaps
        step(1'b1, 32'h00B50533, 32'd0, 32'hA, 32'd1, 1'b0);
        step(1'b1, 32'h00B50533, 32'd0, 32'hB, 32'd1, 1'b0);
        check("bp_ready_low", 64'(instr_ready_o), 64'd0);
        step(1'b1, 32'h00B50533, 32'd0, 32'hC, 32'd1, 1'b0);
        check("bp_hold_A", 64'(alu_in1_o), 64'hA);
        step(1'b1, 32'h00B50533, 32'd0, 32'hC, 32'd1, 1'b1);
        check("bp_out_B", 64'(alu_in1_o), 64'hB);
        step(1'b1, 32'h00B50533, 32'd0, 32'hC, 32'd1, 1'b1);
        check("bp_out_C", 64'(alu_in1_o), 64'hC);
        check("bp_no_gap", 64'(alu_valid_o), 64'd1);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        check("bp_drained", 64'(alu_valid_o), 64'd0);

        // Reset while two commands are held
        step(1'b1, 32'h00B50533, 32'd0, 32'h1, 32'd1, 1'b0);
        step(1'b1, 32'h00B50533, 32'd0, 32'h2, 32'd1, 1'b0);
        apply_reset();
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        check("rst_mid_ready", 64'(instr_ready_o), 64'd1);
        check("rst_mid_stale", 64'(alu_valid_o), 64'd0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
